spi_rx_word_packer: RTL

- Sits directly downstream of the SPI slave byte interface, in the i_Clk domain.
- Collects received bytes (RX_DV/RX_Byte) into DATA_WIDTH-bit little-endian words and buffers them in a first-word-fall-through FIFO.
- Presents the words as a valid/ready stream to the command parser.
- Feeds a status byte back to the slave's TX input so the SPI master can poll free space and overflow.

---
 rtl/spi_rx_word_packer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/spi_rx_word_packer.sv
// Packs SPI slave RX bytes into little-endian words, buffers them in a first-word-fall-through
// FIFO for the command parser and returns a {overflow, free_words} status byte to the slave TX.
module spi_rx_word_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_L,
    input  logic                          i_RX_DV,
    input  logic [7:0]                    i_RX_Byte,
    input  logic                          i_SPI_CS_n,
    output logic                          o_TX_DV,
    output logic [7:0]                    o_TX_Byte,
    output logic [DATA_WIDTH-1:0]         o_M_Data,
    output logic                          o_M_Valid,
    input  logic                          i_M_Ready,
    output logic                          o_Frame_Err,
    output logic                          o_Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_Level
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(NB - 1);

    logic                  cs_meta_q, cs_sync_q, cs_prev_q;
    logic                  cs_fall, cs_rise;

    logic [CW-1:0]         byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  push_req;
    logic                  frame_err_q, frame_err_d;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         level_q, level_d;
    logic                  pop, push_ok;
    logic                  overflow_q, overflow_d;

    logic                  start_q;
    logic                  tx_dv_q, tx_dv_d;
    logic [7:0]            tx_byte_q, tx_byte_d;
    logic [31:0]           free_words;

    // Chip select idles high, so the synchronizer resets to 1 to avoid a false edge.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cs_meta_q <= 1'b1;
            cs_sync_q <= 1'b1;
            cs_prev_q <= 1'b1;
        end else begin
            cs_meta_q <= i_SPI_CS_n;
            cs_sync_q <= cs_meta_q;
            cs_prev_q <= cs_sync_q;
        end
    end

    assign cs_fall = cs_prev_q & ~cs_sync_q;
    assign cs_rise = ~cs_prev_q & cs_sync_q;

    // The incoming byte is applied first so a coincident CS release sees the updated count.
    always_comb begin
        shreg_d     = shreg_q;
        byte_cnt_d  = byte_cnt_q;
        push_req    = 1'b0;
        frame_err_d = 1'b0;
        if (i_RX_DV) begin
            shreg_d[8*int'(byte_cnt_q) +: 8] = i_RX_Byte;
            if (byte_cnt_q == LAST_LANE) begin
                push_req   = 1'b1;
                byte_cnt_d = '0;
            end else begin
                byte_cnt_d = byte_cnt_q + CW'(1);
            end
        end
        if (cs_rise && (byte_cnt_d != '0)) begin
            frame_err_d = 1'b1;
            byte_cnt_d  = '0;
        end
        if (cs_fall) begin
            byte_cnt_d = '0;
        end
    end

    assign o_M_Valid = (level_q != '0);
    assign o_M_Data  = o_M_Valid ? mem_q[rd_ptr_q] : '0;
    assign pop       = o_M_Valid && i_M_Ready;
    assign push_ok   = push_req && ((level_q < LW'(FIFO_DEPTH)) || pop);

    always_comb begin
        level_d    = level_q + LW'(push_ok) - LW'(pop);
        overflow_d = overflow_q;
        if (cs_fall) begin
            overflow_d = 1'b0;
        end
        if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end
        free_words = 32'(FIFO_DEPTH) - 32'(level_d);
        tx_byte_d  = {overflow_d, (free_words > 32'd127) ? 7'h7F : free_words[6:0]};
        tx_dv_d    = i_RX_DV | cs_rise | start_q;
    end

    always_ff @(posedge i_Clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= shreg_d;
        end
    end

    // start_q forces one status load right after reset so the master sees the empty FIFO.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            byte_cnt_q  <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            start_q     <= 1'b1;
            tx_dv_q     <= 1'b0;
            tx_byte_q   <= '0;
        end else begin
            byte_cnt_q  <= byte_cnt_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            start_q     <= 1'b0;
            tx_dv_q     <= tx_dv_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (tx_dv_d) begin
                tx_byte_q <= tx_byte_d;
            end
        end
    end

    assign o_TX_DV     = tx_dv_q;
    assign o_TX_Byte   = tx_byte_q;
    assign o_Frame_Err = frame_err_q;
    assign o_Overflow  = overflow_q;
    assign o_Level     = level_q;

endmodule
